ext_mem_bus_arbiter: RTL and testbench
======================================

// Module: ext_mem_bus_arbiter
// PURPOSE
//  Shares the single off-chip memory bus (16-bit address, 8-bit bidirectional data, write strobe) between two requesters.
//  Requester 0 is the core; requester 1 is the loader/debug port.
//  Sequences each access as SETUP -> ACCESS (wait states) -> HOLD and drives the data-pin output enables.
//  Sits between the requesters and the gpio pad mapping.
// PARAMETERS
//  WAIT_CYCLES  2   ACCESS-phase length in cycles; legal range 1..15
// PORTS
//  clk          in   1   system clock
//  rst          in   1   synchronous reset, active-high
//  req          in   2   per-requester request; held until its gnt bit
//  we           in   2   per-requester: 1 = write, 0 = read
//  addr0/addr1  in   16  requester address
//  wdata0/1     in   8   requester write data
//  gnt          out  2   one-hot accept pulse (Mealy, IDLE only)
//  rvalid       out  2   one-cycle read-data-valid pulse, to the owner
//  rdata        out  8   read data; holds until the next read completes
//  busy         out  1   1 whenever state != IDLE
//  mem_addr     out  16  to address pins
//  mem_wdata    out  8   to data pins
//  mem_rdata    in   8   from data pins
//  mem_wr       out  1   write strobe, active-high
//  mem_oeb      out  8   data-pin output enable, active-low (all bits equal)
// BEHAVIOUR
//  Reset: state=IDLE; mem_wr=0; mem_oeb=8'hFF; mem_addr=0; mem_wdata=0.
//   rdata=0; rvalid=0; busy=0; round-robin pointer=0 (req0 favoured next).
//   Reset in any state aborts the access at that edge; mem_wr drops the next cycle.
//  Arbitration (IDLE only):
//   - Exactly one req bit set -> that bit wins.
//   - Both set -> the requester not granted last wins; pointer flips on every grant.
//   - gnt[i] = (state==IDLE) & win[i]; zero outside IDLE.
//   - On the gnt edge, latch the winner's we/addr/wdata and owner id, go to SETUP.
//  FSM, all transitions on clk:
//   - IDLE -> SETUP on any req, else stay.
//   - SETUP (1 cycle): mem_addr=latched addr; mem_wr=0.
//     mem_oeb=00 if write, FF if read; mem_wdata=latched data. -> ACCESS, cnt=0.
//   - ACCESS (WAIT_CYCLES cycles): write -> mem_wr=1; read -> mem_oeb=FF.
//     Read samples mem_rdata into rdata on the edge leaving the last ACCESS cycle (cnt==WAIT_CYCLES-1). -> HOLD.
//   - HOLD (1 cycle): mem_wr=0.
//     Write: addr/wdata/oeb held, giving data hold past the strobe.
//     Read: rvalid[owner]=1 in this cycle. -> IDLE.
//   - IDLE outputs: mem_oeb=FF and mem_wr=0; mem_addr/mem_wdata keep their last value.
//  Latency/throughput:
//   - gnt at cycle T; SETUP T+1; ACCESS T+2..T+1+W; HOLD T+2+W (rvalid); next gnt possible T+3+W.
//   - Peak rate: one access per WAIT_CYCLES+3 cycles.
//  Boundaries:
//   - Requests arriving while busy wait; no queueing beyond req-hold.
//   - Requester drops req before gnt: the request is lost silently. Not an error.
//   - req changes during an access have no effect on the latched transaction.
//   - mem_wr never asserts outside ACCESS.
//   - mem_oeb is 00 only in SETUP/ACCESS/HOLD of a write.
//   - WAIT_CYCLES=1: ACCESS is one cycle; cnt width is 4 bits regardless.
// STRUCTURE
//  ext_mem_pkg:
//   - typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} mem_state_t;
//   - localparams MEM_ADDR_W=16, MEM_DATA_W=8;
//   - typedef struct {we, addr, wdata} mem_req_t.
//  Sub-module rr_arb2: req[1:0] + pointer -> one-hot win[1:0]; pointer update on grant.
//  The FSM, wait counter and output registers stay in this module.
// TESTING
//  1. Reset, then req=01 write addr=16'h1234 wdata=8'hA5 (W=2):
//     gnt=01 at T; mem_wr=1 only at T+2..T+3; oeb=00 at T+1..T+4; busy=0 at T+5.
//  2. req=10 read addr=16'h00FF, mem_rdata=8'h3C during ACCESS:
//     rvalid=10 at T+4; rdata=8'h3C held until the next read.
//  3. Both requesters hold req continuously:
//     gnt alternates 01,10,01,...; one grant every 5 cycles; no requester starved.
//  4. Assert rst during ACCESS of a write:
//     next cycle mem_wr=0, mem_oeb=FF, busy=0; next grant goes to req0.
//  5. WAIT_CYCLES=1 read:
//     rvalid at T+3; mem_rdata sampled exactly at the T+2 -> T+3 edge (change it at T+3 -> no effect).
//  6. req0 pulses for one cycle while busy, then drops:
//     no gnt, no memory activity; req1 is unaffected.

Source files
------------

// File: rtl/ext_mem_bus_arbiter_pkg.sv
// Shared types and widths for the external memory bus arbiter.
// The transaction record is what the arbiter latches from the winning requester.
package ext_mem_bus_arbiter_pkg;

    localparam int MEM_ADDR_W = 16;
    localparam int MEM_DATA_W = 8;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} mem_state_t;

    typedef struct packed {
        logic                  we;
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] wdata;
    } mem_req_t;

    localparam logic [MEM_DATA_W-1:0] OEB_DRIVE = '0;
    localparam logic [MEM_DATA_W-1:0] OEB_FLOAT = '1;

    // Data pins are only driven by us for a write; reads leave the pads floating.
    function automatic logic [MEM_DATA_W-1:0] oeb_for(input logic we);
        return we ? OEB_DRIVE : OEB_FLOAT;
    endfunction

endpackage

// File: rtl/ext_mem_bus_arbiter_if.sv
// Requester handshake plus off-chip memory pins, bundled for the arbiter.
// master = arbiter view, slave = requesters/pad-side view.
interface ext_mem_bus_arbiter_if;
    import ext_mem_bus_arbiter_pkg::*;

    logic [1:0]            req;
    logic [1:0]            we;
    logic [MEM_ADDR_W-1:0] addr0;
    logic [MEM_ADDR_W-1:0] addr1;
    logic [MEM_DATA_W-1:0] wdata0;
    logic [MEM_DATA_W-1:0] wdata1;
    logic [1:0]            gnt;
    logic [1:0]            rvalid;
    logic [MEM_DATA_W-1:0] rdata;
    logic                  busy;

    logic [MEM_ADDR_W-1:0] mem_addr;
    logic [MEM_DATA_W-1:0] mem_wdata;
    logic [MEM_DATA_W-1:0] mem_rdata;
    logic                  mem_wr;
    logic [MEM_DATA_W-1:0] mem_oeb;

    modport master (
        input  req, we, addr0, addr1, wdata0, wdata1, mem_rdata,
        output gnt, rvalid, rdata, busy, mem_addr, mem_wdata, mem_wr, mem_oeb
    );

    modport slave (
        output req, we, addr0, addr1, wdata0, wdata1, mem_rdata,
        input  gnt, rvalid, rdata, busy, mem_addr, mem_wdata, mem_wr, mem_oeb
    );

endinterface

// File: rtl/ext_mem_bus_arbiter_rr_arb2.sv
// Two-way round-robin picker: a lone request always wins, a tie goes to the
// requester that was not granted last. Pointer = index favoured on the next tie.
module ext_mem_bus_arbiter_rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] win_o
);

    logic ptr_q;
    logic ptr_d;

    always_comb begin
        case (req_i)
            2'b01:   win_o = 2'b01;
            2'b10:   win_o = 2'b10;
            2'b11:   win_o = ptr_q ? 2'b10 : 2'b01;
            default: win_o = 2'b00;
        endcase
    end

    always_comb begin
        ptr_d = ptr_q;
        if (en_i && (win_o != 2'b00)) begin
            ptr_d = win_o[0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/ext_mem_bus_arbiter.sv
// Shares the off-chip memory bus between the core (0) and loader/debug port (1),
// sequencing each access as SETUP -> ACCESS (wait states) -> HOLD.
//
//  state  | meaning
//  IDLE   | bus parked, pins floating, grant decided combinationally
//  SETUP  | address/data presented, strobe still low
//  ACCESS | WAIT_CYCLES cycles of strobe (write) or pad settling (read)
//  HOLD   | strobe low, address/data held; read data returned to owner
module ext_mem_bus_arbiter
    import ext_mem_bus_arbiter_pkg::*;
#(
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    ext_mem_bus_arbiter_if.master bus_io
);

    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_SETUP  = SETUP;
    localparam logic [1:0] ST_ACCESS = ACCESS;
    localparam logic [1:0] ST_HOLD   = HOLD;

    localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES - 1);

    logic [1:0]            state_q,   state_d;
    logic [3:0]            cnt_q,     cnt_d;
    mem_req_t              txn_q,     txn_d;
    logic                  owner_q,   owner_d;
    logic                  mem_wr_q,  mem_wr_d;
    logic [MEM_DATA_W-1:0] mem_oeb_q, mem_oeb_d;
    logic [MEM_DATA_W-1:0] rdata_q,   rdata_d;
    logic [1:0]            rvalid_q,  rvalid_d;

    logic                  idle;
    logic [1:0]            win;
    mem_req_t              cand0;
    mem_req_t              cand1;

    assign idle  = (state_q == ST_IDLE);
    assign cand0 = {bus_io.we[0], bus_io.addr0, bus_io.wdata0};
    assign cand1 = {bus_io.we[1], bus_io.addr1, bus_io.wdata1};

    ext_mem_bus_arbiter_rr_arb2 u_rr_arb2 (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (idle),
        .req_i (bus_io.req),
        .win_o (win)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        txn_d     = txn_q;
        owner_d   = owner_q;
        mem_wr_d  = mem_wr_q;
        mem_oeb_d = mem_oeb_q;
        rdata_d   = rdata_q;
        rvalid_d  = 2'b00;

        case (state_q)
            ST_IDLE: begin
                mem_wr_d  = 1'b0;
                mem_oeb_d = OEB_FLOAT;
                if (win != 2'b00) begin
                    state_d   = ST_SETUP;
                    owner_d   = win[1];
                    txn_d     = win[1] ? cand1 : cand0;
                    mem_oeb_d = oeb_for(txn_d.we);
                end
            end
            ST_SETUP: begin
                state_d  = ST_ACCESS;
                cnt_d    = 4'd0;
                mem_wr_d = txn_q.we;
            end
            ST_ACCESS: begin
                if (cnt_q == CNT_LAST) begin
                    state_d  = ST_HOLD;
                    mem_wr_d = 1'b0;
                    if (!txn_q.we) begin
                        rdata_d  = bus_io.mem_rdata;
                        rvalid_d = owner_q ? 2'b10 : 2'b01;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_HOLD: begin
                // Address, data and output enables stay put through HOLD for write hold time.
                state_d   = ST_IDLE;
                mem_oeb_d = OEB_FLOAT;
            end
            default: begin
                state_d   = ST_IDLE;
                mem_wr_d  = 1'b0;
                mem_oeb_d = OEB_FLOAT;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            txn_q     <= '0;
            owner_q   <= 1'b0;
            mem_wr_q  <= 1'b0;
            mem_oeb_q <= OEB_FLOAT;
            rdata_q   <= '0;
            rvalid_q  <= 2'b00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            txn_q     <= txn_d;
            owner_q   <= owner_d;
            mem_wr_q  <= mem_wr_d;
            mem_oeb_q <= mem_oeb_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
        end
    end

    assign bus_io.gnt       = idle ? win : 2'b00;
    assign bus_io.busy      = ~idle;
    assign bus_io.rvalid    = rvalid_q;
    assign bus_io.rdata     = rdata_q;
    assign bus_io.mem_addr  = txn_q.addr;
    assign bus_io.mem_wdata = txn_q.wdata;
    assign bus_io.mem_wr    = mem_wr_q;
    assign bus_io.mem_oeb   = mem_oeb_q;

endmodule

// File: tb/tb_ext_mem_bus_arbiter.sv
// Bench for ext_mem_bus_arbiter: W=2 instance checked every cycle against a
// phase-timeline model, W=1 instance checked with directed tables.
module tb_ext_mem_bus_arbiter;
    import ext_mem_bus_arbiter_pkg::*;

    localparam int W = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ext_mem_bus_arbiter_if bus_a ();
    ext_mem_bus_arbiter_if bus_b ();

    ext_mem_bus_arbiter #(.WAIT_CYCLES(2)) dut_a (.clk_i(clk), .rst_i(rst), .bus_io(bus_a));
    ext_mem_bus_arbiter #(.WAIT_CYCLES(1)) dut_b (.clk_i(clk), .rst_i(rst), .bus_io(bus_b));

    int n_vec = 0;
    int n_err = 0;

    // Reference model: one transaction in flight, timed by phase = cycle - grant cycle.
    int          cyc = 0;
    bit          m_act;
    int          m_g;
    bit          m_own;
    bit          m_we;
    logic [15:0] m_addr;
    logic [7:0]  m_wdata;
    logic [7:0]  m_rdata;
    bit          m_ptr;
    logic [1:0]  m_gnt;
    bit          auto_drop;
    bit          force_rd;
    int          g_cnt0, g_cnt1;

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_a();
        logic [1:0] win;
        logic [1:0] exp_rv;
        logic [7:0] exp_oeb;
        logic       exp_wr;
        int         p;
        @(negedge clk);
        if (rst) begin
            m_act = 0; m_ptr = 0; m_addr = '0; m_wdata = '0; m_rdata = '0; m_gnt = 2'b00;
        end else begin
            p   = cyc - m_g;
            win = 2'b00;
            if (!m_act) begin
                if (bus_a.req == 2'b01)      win = 2'b01;
                else if (bus_a.req == 2'b10) win = 2'b10;
                else if (bus_a.req == 2'b11) win = m_ptr ? 2'b10 : 2'b01;
            end
            exp_wr  = m_act && m_we && (p >= 2) && (p <= 1 + W);
            exp_oeb = (m_act && m_we) ? 8'h00 : 8'hFF;
            exp_rv  = (m_act && !m_we && p == 2 + W) ? (m_own ? 2'b10 : 2'b01) : 2'b00;
            cmp("gnt",       bus_a.gnt, win);
            cmp("busy",      bus_a.busy, m_act);
            cmp("mem_wr",    bus_a.mem_wr, exp_wr);
            cmp("mem_oeb",   bus_a.mem_oeb, exp_oeb);
            cmp("rvalid",    bus_a.rvalid, exp_rv);
            cmp("rdata",     bus_a.rdata, m_rdata);
            cmp("mem_addr",  bus_a.mem_addr, m_addr);
            cmp("mem_wdata", bus_a.mem_wdata, m_wdata);
            if (bus_a.gnt[0]) g_cnt0++;
            if (bus_a.gnt[1]) g_cnt1++;
            if (m_act && !m_we && p == 1 + W) m_rdata = bus_a.mem_rdata;
            if (m_act && p == 2 + W) m_act = 0;
            if (win != 2'b00) begin
                m_act   = 1;
                m_g     = cyc;
                m_own   = win[1];
                m_we    = bus_a.we[win[1]];
                m_addr  = win[1] ? bus_a.addr1 : bus_a.addr0;
                m_wdata = win[1] ? bus_a.wdata1 : bus_a.wdata0;
                m_ptr   = win[0];
            end
            m_gnt = win;
        end
        cyc++;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
        if (auto_drop) bus_a.req = bus_a.req & ~m_gnt;
        bus_a.mem_rdata = force_rd ? 8'h3C : 8'($urandom);
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            chk_a();
            adv();
        end
    endtask

    logic       wr_tab   [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [7:0] oeb_tab  [5] = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'hFF};
    logic       busy_tab [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [1:0] gnt_tab  [5] = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b00};

    initial begin
        rst = 1'b1;
        auto_drop = 1; force_rd = 0;
        bus_a.req = '0; bus_a.we = '0; bus_a.addr0 = '0; bus_a.addr1 = '0;
        bus_a.wdata0 = '0; bus_a.wdata1 = '0; bus_a.mem_rdata = '0;
        bus_b.req = '0; bus_b.we = '0; bus_b.addr0 = '0; bus_b.addr1 = '0;
        bus_b.wdata0 = '0; bus_b.wdata1 = '0; bus_b.mem_rdata = '0;
        step(2);
        rst = 1'b0;
        step(2);

        // Core write
        bus_a.req = 2'b01; bus_a.we = 2'b01; bus_a.addr0 = 16'h1234; bus_a.wdata0 = 8'hA5;
        step(7);

        // Loader read with fixed pad data
        force_rd = 1; bus_a.mem_rdata = 8'h3C;
        bus_a.req = 2'b10; bus_a.we = 2'b00; bus_a.addr1 = 16'h00FF;
        step(7);
        force_rd = 0;
        bus_a.req = 2'b01; bus_a.we = 2'b01; bus_a.addr0 = 16'h5555; bus_a.wdata0 = 8'h11;
        step(7);
        cmp("t2_rdata_held", bus_a.rdata, 8'h3C);

        // Both requesters hold req continuously
        auto_drop = 0; g_cnt0 = 0; g_cnt1 = 0;
        bus_a.req = 2'b11; bus_a.we = 2'b10;
        step(20);
        cmp("t3_grants_req0", g_cnt0, 2);
        cmp("t3_grants_req1", g_cnt1, 2);
        bus_a.req = 2'b00; auto_drop = 1;
        step(6);

        // Reset during a write ACCESS; pointer returns to req0
        bus_a.req = 2'b01; bus_a.we = 2'b01; bus_a.addr0 = 16'hCAFE; bus_a.wdata0 = 8'h5A;
        step(2);
        rst = 1'b1;
        step(1);
        rst = 1'b0; bus_a.req = 2'b11;
        chk_a();
        cmp("t4_mem_wr", bus_a.mem_wr, 1'b0);
        cmp("t4_mem_oeb", bus_a.mem_oeb, 8'hFF);
        cmp("t4_busy", bus_a.busy, 1'b0);
        cmp("t4_gnt", bus_a.gnt, 2'b01);
        adv();
        step(12);

        // req0 pulses while busy and drops: request lost, req1 unaffected
        bus_a.req = 2'b10; bus_a.we = 2'b00; bus_a.addr1 = 16'h0F0F;
        step(1);
        bus_a.req = 2'b01; bus_a.we = 2'b01;
        step(1);
        bus_a.req = 2'b00;
        g_cnt0 = 0;
        step(8);
        cmp("t6_no_gnt_req0", g_cnt0, 0);

        // Randomized traffic, occasional drops and resets
        for (int k = 0; k < 300; k++) begin
            chk_a();
            adv();
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 99) == 0) rst = 1'b1;
            for (int i = 0; i < 2; i++) begin
                if (!bus_a.req[i] && $urandom_range(0, 3) == 0) begin
                    bus_a.req[i] = 1'b1;
                    bus_a.we[i]  = 1'($urandom);
                    if (i == 0) begin bus_a.addr0 = 16'($urandom); bus_a.wdata0 = 8'($urandom); end
                    else        begin bus_a.addr1 = 16'($urandom); bus_a.wdata1 = 8'($urandom); end
                end else if (bus_a.req[i] && $urandom_range(0, 15) == 0) begin
                    bus_a.req[i] = 1'b0;
                end
            end
        end
        rst = 1'b0; bus_a.req = 2'b00;
        step(6);

        // WAIT_CYCLES=1 read: sampled on the T+2 -> T+3 edge only
        bus_b.req = 2'b10; bus_b.we = 2'b00; bus_b.addr1 = 16'h4321; bus_b.mem_rdata = 8'h11;
        chk_a(); cmp("t5_gnt", bus_b.gnt, 2'b10); adv();
        bus_b.req = 2'b00;
        chk_a(); cmp("t5_busy_setup", bus_b.busy, 1'b1); adv();
        bus_b.mem_rdata = 8'h5A;
        chk_a(); cmp("t5_rvalid_access", bus_b.rvalid, 2'b00); adv();
        bus_b.mem_rdata = 8'hC3;
        chk_a();
        cmp("t5_rvalid_hold", bus_b.rvalid, 2'b10);
        cmp("t5_rdata_hold", bus_b.rdata, 8'h5A);
        cmp("t5_addr", bus_b.mem_addr, 16'h4321);
        adv();
        chk_a();
        cmp("t5_busy_after", bus_b.busy, 1'b0);
        cmp("t5_rdata_kept", bus_b.rdata, 8'h5A);
        cmp("t5_rvalid_after", bus_b.rvalid, 2'b00);
        adv();

        // WAIT_CYCLES=1 write: one strobe cycle, enables through HOLD
        bus_b.req = 2'b01; bus_b.we = 2'b01; bus_b.addr0 = 16'hBEEF; bus_b.wdata0 = 8'h77;
        for (int k = 0; k < 5; k++) begin
            chk_a();
            cmp("t5w_gnt", bus_b.gnt, gnt_tab[k]);
            cmp("t5w_mem_wr", bus_b.mem_wr, wr_tab[k]);
            cmp("t5w_mem_oeb", bus_b.mem_oeb, oeb_tab[k]);
            cmp("t5w_busy", bus_b.busy, busy_tab[k]);
            if (k > 0) cmp("t5w_wdata", bus_b.mem_wdata, 8'h77);
            adv();
            bus_b.req = 2'b00;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
